// File: rtl/spi_pkg.sv
// Shared SPI definitions: default word geometry and the FSM state encoding,
// used by both slave- and master-side code.
package spi_pkg;

  localparam int unsigned SPI_DAT_WIDTH = 3;
  localparam int unsigned SPI_LOG_WIDTH = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spiState_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous input plus a third stage
// that yields one-clk rise/fall strobes.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic syncRst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s0, s1, prev;

  always_ff @(posedge clk) begin
    if (syncRst) begin
      s0   <= RST_VAL;
      s1   <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      s0   <= din;
      s1   <= s0;
      prev <= s1;
    end
  end

  assign level = s1;
  assign rise  = s1 & ~prev;
  assign fall  = ~s1 & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first within a byte, byte 0 first on the wire.
// All SPI pins are oversampled in the clk domain.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned DAT_WIDTH = SPI_DAT_WIDTH,
  parameter int unsigned LOG_WIDTH = SPI_LOG_WIDTH
) (
  input  logic                   clk,
  input  logic                   syncRst,
  input  logic                   SCK,
  input  logic                   SS_N,
  input  logic                   MOSI,
  output logic                   MISO,
  output logic                   misoOe,
  input  logic [DAT_WIDTH*8-1:0] txData,
  input  logic                   txLoad,
  output logic                   txFull,
  output logic [DAT_WIDTH*8-1:0] rxData,
  output logic                   rxValid,
  output logic                   rxAbort,
  output logic                   txUnderrun
);

  localparam int unsigned W = DAT_WIDTH * 8;

  // Shift registers run MSB-first, so byte 0 has to sit in the top byte.
  function automatic logic [W-1:0] byteSwap(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < DAT_WIDTH; i++)
      r[8*(DAT_WIDTH-1-i) +: 8] = v[8*i +: 8];
    return r;
  endfunction

  spiState_t state, stateNext;

  logic sckLevel, sckRise, sckFall;
  logic ssLevel, ssRise, ssFall;
  logic mosiS0, mosiS;

  logic [2:0]           bitCnt;
  logic [LOG_WIDTH-1:0] byteCnt;
  logic [W-1:0]         rxShift, txShift, holdReg;
  logic                 wordDone;
  logic [1:0]           settle;
  logic                 armed;

  logic startLoad, abortNow, shiftIn, shiftOut, lastBit, cntBusy;

  spi_sync_edge #(.RST_VAL(1'b0)) uSckSync (
    .clk(clk), .syncRst(syncRst), .din(SCK),
    .level(sckLevel), .rise(sckRise), .fall(sckFall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) uSsSync (
    .clk(clk), .syncRst(syncRst), .din(SS_N),
    .level(ssLevel), .rise(ssRise), .fall(ssFall)
  );

  assign lastBit = (bitCnt == 3'd7) && (byteCnt == LOG_WIDTH'(DAT_WIDTH - 1));
  assign cntBusy = (bitCnt != '0) || (byteCnt != '0);

  always_ff @(posedge clk) begin
    if (syncRst) state <= IDLE;
    else         state <= stateNext;
  end

  // A fall right after a word completes only closes the last bit; the
  // freshly loaded word must not shift until its own first rising edge.
  always_comb begin
    stateNext = state;
    startLoad = 1'b0;
    abortNow  = 1'b0;
    shiftIn   = 1'b0;
    shiftOut  = 1'b0;
    case (state)
      IDLE: begin
        if (ssFall && armed) begin
          stateNext = SHIFT;
          startLoad = 1'b1;
        end
      end
      SHIFT: begin
        if (ssRise) begin
          stateNext = IDLE;
          abortNow  = cntBusy;
        end else begin
          shiftIn   = sckRise;
          shiftOut  = sckFall && cntBusy;
          startLoad = wordDone;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (syncRst) begin
      mosiS0     <= 1'b0;
      mosiS      <= 1'b0;
      bitCnt     <= '0;
      byteCnt    <= '0;
      wordDone   <= 1'b0;
      rxShift    <= '0;
      txShift    <= '0;
      holdReg    <= '0;
      txFull     <= 1'b0;
      rxData     <= '0;
      rxValid    <= 1'b0;
      rxAbort    <= 1'b0;
      txUnderrun <= 1'b0;
      settle     <= '0;
      armed      <= 1'b0;
    end else begin
      mosiS0 <= MOSI;
      mosiS  <= mosiS0;

      // After reset only a line seen idle (SS_N high, SCK low) re-arms,
      // so an SS_N-low period that straddles reset is ignored.
      if (settle != 2'd3) settle <= settle + 2'd1;
      if (settle == 2'd3 && ssLevel && !sckLevel) armed <= 1'b1;

      wordDone <= shiftIn && lastBit;
      if (stateNext == IDLE) begin
        bitCnt  <= '0;
        byteCnt <= '0;
      end else if (shiftIn) begin
        rxShift <= {rxShift[W-2:0], mosiS};
        if (lastBit) begin
          bitCnt  <= '0;
          byteCnt <= '0;
        end else begin
          bitCnt <= bitCnt + 3'd1;
          if (bitCnt == 3'd7) byteCnt <= byteCnt + LOG_WIDTH'(1);
        end
      end

      rxValid <= wordDone;
      if (wordDone) rxData <= byteSwap(rxShift);
      rxAbort <= abortNow;

      if (startLoad)     txShift <= txFull ? byteSwap(holdReg) : '0;
      else if (shiftOut) txShift <= {txShift[W-2:0], 1'b0};
      txUnderrun <= startLoad && !txFull;

      if (txLoad) begin
        holdReg <= txData;
        txFull  <= 1'b1;
      end else if (startLoad) begin
        txFull <= 1'b0;
      end
    end
  end

  assign misoOe = (state == SHIFT);
  assign MISO   = misoOe ? txShift[W-1] : 1'b0;

endmodule
